// File: rtl/acc_shift_seq.sv
// acc_shift_seq: sequential EDSAC accumulator shifter.
// Runs L/R orders one place per clock with a start/busy/done handshake.
module acc_shift_seq #(
  parameter int WIDTH  = 71,
  parameter int CODE_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              c7,
  input  logic              c8,
  input  logic [CODE_W-1:0] code,
  input  logic              load,
  input  logic [WIDTH-1:0]  acc_d,
  output logic [WIDTH-1:0]  acc_q,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [3:0]        x
);

  localparam int CNT_W = $clog2(CODE_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_init;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_shifted;
  logic             r_left;
  logic             r_sign0;
  logic             r_ovf;
  logic             w_degen;
  logic             w_last;
  logic             w_go_r;
  logic             w_go_l;

  // Shift count = index of the lowest set code bit, plus one.
  always_comb begin
    w_cnt_init = '0;
    for (int i = CODE_W - 1; i >= 0; i--) begin
      if (code[i]) begin
        w_cnt_init = CNT_W'(i + 1);
      end
    end
  end

  // No unique direction or no count: finish without shifting.
  assign w_degen = (c7 == c8) || (code == '0);
  assign w_last  = (r_cnt == CNT_W'(1));

  // One-place shift of the current image in the latched direction.
  always_comb begin
    w_shifted = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
    if (r_left) begin
      w_shifted = {r_acc[WIDTH-2:0], 1'b0};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_degen ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Accumulator, counter, direction and overflow tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_left  <= 1'b0;
      r_sign0 <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            if (!w_degen) begin
              r_left  <= c8;
              r_cnt   <= w_cnt_init;
              r_ovf   <= 1'b0;
              r_sign0 <= r_acc[WIDTH-1];
            end
          end else if (load) begin
            r_acc <= acc_d;
          end
        end
        S_SHIFT: begin
          r_acc <= w_shifted;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_left && (w_shifted[WIDTH-1] != r_sign0)) begin
            r_ovf <= 1'b1;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Outputs decoded only from registers.
  assign busy   = (r_state == S_SHIFT);
  assign done   = (r_state == S_DONE);
  assign acc_q  = r_acc;
  assign ovf    = r_ovf;
  assign w_go_r = busy & ~r_left;
  assign w_go_l = busy & r_left;
  assign x      = {w_go_l, ~w_go_l, ~w_go_r, w_go_r};

endmodule

// File: tb/tb_acc_shift_seq.sv
// tb_acc_shift_seq: directed bench for acc_shift_seq.
// Queue-based timeline model plus literal spot checks.
module tb_acc_shift_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       c7 = 1'b0;
  logic       c8 = 1'b0;
  logic [4:0] code = '0;
  logic       load = 1'b0;
  logic [7:0] acc_d = '0;
  logic [7:0] acc_q;
  logic       busy;
  logic       done;
  logic       ovf;
  logic [3:0] x;

  acc_shift_seq #(.WIDTH(8), .CODE_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .c7(c7), .c8(c8),
    .code(code), .load(load), .acc_d(acc_d), .acc_q(acc_q),
    .busy(busy), .done(done), .ovf(ovf), .x(x)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] acc;
    logic       ovf;
    logic       busy;
    logic       done;
    logic       left;
  } exp_t;

  exp_t cur = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
  exp_t q[$];

  int n_chk_m = 0;
  int n_fail_m = 0;
  int n_chk_d = 0;
  int n_fail_d = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  // Timeline model: an accepted order expands to its full cycle list.
  int         m_n;
  int         m_tmp;
  logic [7:0] m_a0;
  logic [7:0] m_v;
  logic       m_ov;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      cur = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    end else if (q.size() != 0) begin
      cur = q.pop_front();
    end else if (cur.done) begin
      cur.done = 1'b0;
    end else if (start) begin
      m_n = 0;
      for (int i = 4; i >= 0; i--) if (code[i]) m_n = i + 1;
      if (c7 == c8 || m_n == 0) begin
        cur.done = 1'b1;
      end else begin
        m_a0 = cur.acc;
        m_ov = 1'b0;
        cur.busy = 1'b1;
        cur.ovf = 1'b0;
        cur.left = c8;
        for (int k = 1; k <= m_n; k++) begin
          if (c8) begin
            m_tmp = int'(m_a0) << k;
            m_v = m_tmp[7:0];
            if (m_v[7] != m_a0[7]) m_ov = 1'b1;
          end else begin
            m_v = $signed(m_a0) >>> k;
          end
          q.push_back('{m_v, m_ov, k < m_n, k == m_n, c8});
        end
      end
    end else if (load) begin
      cur.acc = acc_d;
    end
  end

  // Every-cycle comparison against the model.
  logic [3:0] m_x;
  always @(negedge clk) begin
    m_x = {cur.busy & cur.left, ~(cur.busy & cur.left),
           ~(cur.busy & ~cur.left), cur.busy & ~cur.left};
    n_chk_m++;
    if (acc_q !== cur.acc || busy !== cur.busy || done !== cur.done ||
        ovf !== cur.ovf || x !== m_x) begin
      n_fail_m++;
      $display("FAIL model t=%0t acc=%h/%h busy=%b/%b done=%b/%b ovf=%b/%b x=%b/%b",
               $time, acc_q, cur.acc, busy, cur.busy, done, cur.done,
               ovf, cur.ovf, x, m_x);
    end
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk_d++;
    if (act !== exp) begin
      n_fail_d++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    #1;
    load = 1'b1;
    acc_d = v;
    @(negedge clk);
    #1;
    load = 1'b0;
  endtask

  int b0;
  int d0;
  task automatic do_start(input logic r, input logic l, input logic [4:0] c);
    @(negedge clk);
    #1;
    b0 = busy_cnt;
    d0 = done_cnt;
    start = 1'b1;
    c7 = r;
    c8 = l;
    code = c;
    @(negedge clk);
    #1;
    start = 1'b0;
    c7 = 1'b0;
    c8 = 1'b0;
    code = '0;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    chk({nm, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_acc", 32'(acc_q), 32'h00);
    chk("rst_x", 32'(x), 32'b0110);
    chk("rst_flags", {busy, done, ovf}, 3'b000);
    @(negedge clk);
    #2;
    rst = 1'b0;

    // Right shift n=3 of 8'h96.
    do_load(8'h96);
    chk("load_96", 32'(acc_q), 32'h96);
    do_start(1'b1, 1'b0, 5'b00100);
    chk("r_x", 32'(x), 32'b0101);
    wait_done("r");
    chk("r_acc", 32'(acc_q), 32'hF2);
    chk("r_busy", 32'(busy_cnt - b0), 32'd3);
    chk("r_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    #1;
    chk("r_done_once", 32'(done_cnt - d0), 32'd1);

    // Left shift n=2 of 8'h35 with overflow on the second place.
    do_load(8'h35);
    do_start(1'b0, 1'b1, 5'b00010);
    chk("l_x", 32'(x), 32'b1010);
    chk("l_ovf0", 32'(ovf), 32'd0);
    @(negedge clk);
    #1;
    chk("l_step1", 32'(acc_q), 32'h6A);
    chk("l_ovf1", 32'(ovf), 32'd0);
    wait_done("l");
    chk("l_step2", 32'(acc_q), 32'hD4);
    chk("l_ovf2", 32'(ovf), 32'd1);

    // Degenerate starts keep acc and the sticky ovf.
    do_start(1'b1, 1'b1, 5'b00001);
    chk("dg1_done", 32'(done), 32'd1);
    chk("dg1_x", 32'(x), 32'b0110);
    chk("dg1_acc", 32'(acc_q), 32'hD4);
    chk("dg1_ovf", 32'(ovf), 32'd1);
    do_start(1'b1, 1'b0, 5'b00000);
    chk("dg2_done", 32'(done), 32'd1);
    chk("dg2_acc", 32'(acc_q), 32'hD4);
    chk("dg2_busy", 32'(busy_cnt - b0), 32'd0);

    // Maximum count, then a single right place.
    do_load(8'h01);
    do_start(1'b0, 1'b1, 5'b10000);
    wait_done("max");
    chk("max_acc", 32'(acc_q), 32'h20);
    chk("max_busy", 32'(busy_cnt - b0), 32'd5);
    chk("max_ovf", 32'(ovf), 32'd0);
    do_start(1'b1, 1'b0, 5'b00001);
    wait_done("r1");
    chk("r1_acc", 32'(acc_q), 32'h10);
    chk("r1_ovf", 32'(ovf), 32'd0);

    // Load/start during a 4-place shift are ignored.
    do_load(8'h81);
    do_start(1'b1, 1'b0, 5'b01000);
    load = 1'b1;
    acc_d = 8'hFF;
    start = 1'b1;
    c8 = 1'b1;
    code = 5'b00001;
    @(negedge clk);
    #1;
    start = 1'b0;
    c8 = 1'b0;
    code = '0;
    @(negedge clk);
    #1;
    load = 1'b0;
    wait_done("ign");
    chk("ign_acc", 32'(acc_q), 32'hF8);
    repeat (3) @(negedge clk);
    #1;
    chk("ign_done_once", 32'(done_cnt - d0), 32'd1);
    chk("ign_busy", 32'(busy_cnt - b0), 32'd4);

    // Async reset in the middle of a left shift.
    do_load(8'h55);
    do_start(1'b0, 1'b1, 5'b01000);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_acc", 32'(acc_q), 32'h00);
    chk("ar_flags", {busy, ovf}, 2'b00);
    chk("ar_x", 32'(x), 32'b0110);
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("ar_no_done", 32'(done_cnt - d0), 32'd0);
    do_load(8'h40);
    do_start(1'b1, 1'b0, 5'b00001);
    wait_done("ar_after");
    chk("ar_after_acc", 32'(acc_q), 32'h20);

    repeat (2) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk_m + n_chk_d, n_fail_m + n_fail_d);
    $finish;
  end

endmodule
